// File: rtl/spram_gen.sv
// Parametrised single-port synchronous RAM with byte-lane writes, read-valid strobe
// and selectable write-cycle read behaviour. Define SPRAM_AUTO_CLEAR_EN to add the post-reset clear sequencer.
module spram_gen #(
  parameter int unsigned           ADDR_WIDTH  = 9,
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           BYTE_SIZE   = 8,
  parameter string                 WRITE_MODE  = "NORMAL_WRITE",
  parameter int unsigned           OUTPUT_REG  = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int unsigned          BE_WIDTH    = (DATA_WIDTH + BYTE_SIZE - 1) / BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam bit          MODE_TRANS = (WRITE_MODE == "TRANSPARENT_WRITE");
  localparam bit          MODE_RBW   = (WRITE_MODE == "READ_BEFORE_WRITE");

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy_w;
  logic [ADDR_WIDTH-1:0] clr_addr_w;

`ifdef SPRAM_AUTO_CLEAR_EN
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    busy_d     = busy_q;
    clr_addr_d = clr_addr_q;
    if (busy_q) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b1;
      clr_addr_q <= '0;
    end else begin
      busy_q     <= busy_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign busy_w     = busy_q;
  assign clr_addr_w = clr_addr_q;
`else
  assign busy_w     = 1'b0;
  assign clr_addr_w = '0;
`endif

  assign busy = busy_w;

  logic                  take;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_mask;

  // Lane enables expanded per bit; the top lane is naturally truncated at DATA_WIDTH.
  always_comb begin
    wr_mask = '0;
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      wr_mask[b] = wr_byte_en[b / BYTE_SIZE];
    end
  end

  always_comb begin
    take      = (wr_en | rd_en) & ~busy_w;
    rd_word   = mem[addr];
    merged    = (rd_word & ~wr_mask) | (wr_data & wr_mask);
    // The clear sequencer owns the write port while busy.
    mem_we    = busy_w | (take & wr_en);
    mem_addr  = busy_w ? clr_addr_w : addr;
    mem_wdata = busy_w ? CLEAR_VALUE : wr_data;
    mem_mask  = busy_w ? '1 : wr_mask;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
        if (mem_mask[b]) mem[mem_addr][b] <= mem_wdata[b];
      end
    end
  end

  logic                  p1_valid_q, p1_valid_d;
  logic [DATA_WIDTH-1:0] p1_data_q, p1_data_d;

  always_comb begin
    p1_valid_d = take & (~wr_en | MODE_TRANS | MODE_RBW);
    p1_data_d  = p1_data_q;
    if (p1_valid_d) p1_data_d = (wr_en && MODE_TRANS) ? merged : rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid_q <= 1'b0;
      p1_data_q  <= '0;
    end else begin
      p1_valid_q <= p1_valid_d;
      p1_data_q  <= p1_data_d;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic                  out_valid_q, out_valid_d;
      logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

      always_comb begin
        out_valid_d = p1_valid_q;
        out_data_d  = p1_valid_q ? p1_data_q : out_data_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          out_data_q  <= out_data_d;
        end
      end

      assign rd_valid = out_valid_q;
      assign rd_data  = out_data_q;
    end else begin : g_noreg
      assign rd_valid = p1_valid_q;
      assign rd_data  = p1_data_q;
    end
  endgenerate

endmodule

// File: doc/spram_gen.md
# spram_gen

Parametrised single-port synchronous RAM: the successor to the fixed 16-bit single-port RAM used for audio sample storage in the WM8731 datapath. It adds:
- configurable width, depth, write mode and output register;
- byte-lane write enables;
- a read-valid strobe;
- an optional post-reset clear sequencer.

The memory array is inferred, so the block synthesises to block RAM on any device. It sits between the codec sample FIFOs/DSP stages and their storage.

## Interface
Parameters:
- ADDR_WIDTH, 9, address bits; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, word width (1..1152).
- BYTE_SIZE, 8, byte-lane width (8 or 9).
- BE_WIDTH, derived localparam = ceil(DATA_WIDTH/BYTE_SIZE); not overridable.
- WRITE_MODE, "NORMAL_WRITE", one of "NORMAL_WRITE", "TRANSPARENT_WRITE", "READ_BEFORE_WRITE".
- OUTPUT_REG, 1, 1 = extra output pipeline register.
- CLEAR_VALUE, {DATA_WIDTH{1'b0}}, word written by the clear sequencer.

Ports:
- clk, in, 1, sole clock; all logic is rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- addr, in, ADDR_WIDTH, word address.
- wr_en, in, 1, write strobe.
- wr_byte_en, in, BE_WIDTH, lane enables for writes.
- wr_data, in, DATA_WIDTH, write word.
- rd_en, in, 1, read strobe.
- rd_data, out, DATA_WIDTH, read word.
- rd_valid, out, 1, one-cycle pulse qualifying rd_data.
- busy, out, 1, clear sequencer active; accesses are ignored while high.

## Operation
- An access is taken at a rising edge when (wr_en | rd_en) & !busy.
- Write cycle (wr_en=1): for each i with wr_byte_en[i]=1, write lane bits [i*BYTE_SIZE +: BYTE_SIZE] at addr.
  - The top lane is truncated to DATA_WIDTH; for example, DATA_WIDTH=20, BYTE_SIZE=9 gives lanes of 9, 9 and 2 bits.
  - Disabled lanes keep their old content.
  - rd_en is ignored on a write cycle (wr_en has priority).
- Write-cycle read port behaviour, by WRITE_MODE:
  - NORMAL_WRITE: rd_data holds its value and no rd_valid pulse is issued.
  - TRANSPARENT_WRITE: the merged new word is presented with an rd_valid pulse.
  - READ_BEFORE_WRITE: the pre-write word is presented with an rd_valid pulse.
- Read cycle (rd_en=1, wr_en=0): the word at addr is presented with an rd_valid pulse.
- rd_data holds its last value until the next valid result; it is never cleared except by reset.
- Reset values:
  - rd_data = 0, rd_valid = 0, all pipeline valids = 0.
  - busy = 0 (1 when the macro is defined).
  - Memory array contents are not reset.
- Back-to-back accesses every cycle are supported at full throughput. Read-after-write to the same address on the next cycle returns the new data.

## Timing
- Access edge T0:
  - OUTPUT_REG=0: rd_data/rd_valid update at T0+1.
  - OUTPUT_REG=1: rd_data/rd_valid update at T0+2.
- rd_valid is high for exactly one cycle per qualifying access and is cycle-aligned with rd_data.
- Reset mid-operation:
  - rd_n low clears rd_valid and rd_data immediately (asynchronously).
  - Accesses in flight are dropped.
  - Completed writes are retained.
- No wrap or overflow conditions exist: addr spans exactly the full depth.

## Configuration
- Macro SPRAM_AUTO_CLEAR_EN.
- Defined: the clear sequencer is compiled in.
  - busy resets to 1.
  - From the first edge after rst_n rises, the sequencer writes CLEAR_VALUE to addresses 0,1,…,2**ADDR_WIDTH-1, one per cycle, ascending.
  - busy falls on the cycle after the last address is written, so busy is high for exactly 2**ADDR_WIDTH cycles.
  - User accesses during busy are dropped: no write, no rd_valid.
  - rst_n asserted mid-clear restarts the sequence from address 0 after release.
- Not defined: no sequencer logic; busy is tied 0; initial memory content is undefined.

## Test plan
- Fill and read back (defaults, OUTPUT_REG=1):
  - Write addr 0..511 with 0xFFFF-addr, all lanes enabled.
  - Read 0..511 back-to-back: each rd_valid arrives exactly 2 cycles after its rd_en, with data 0xFFFF-addr.
  - Exactly 512 rd_valid pulses, no gaps.
- Byte enables:
  - Write 0x1234 to addr 5, then 0xABCD with wr_byte_en=2'b10.
  - Read addr 5 -> 0xAB34.
  - With DATA_WIDTH=20, BYTE_SIZE=9, wr_byte_en=3'b100 alters only bits [19:18].
- Write modes (addr 7 holds 0x1111, write 0x2222 to addr 7):
  - NORMAL_WRITE: rd_data unchanged, rd_valid 0.
  - TRANSPARENT_WRITE: rd_valid with 0x2222.
  - READ_BEFORE_WRITE: rd_valid with 0x1111.
  - A subsequent read of addr 7 returns 0x2222 in all three modes.
- OUTPUT_REG=0 latency: read addr 3 holding 0x00A5 -> rd_valid and 0x00A5 exactly 1 cycle after the access edge.
- Reset mid-read: drop rst_n while 2 reads are in flight.
  - rd_valid and rd_data read 0 immediately.
  - No stray rd_valid after release.
  - Previously written words are intact on re-read.
- SPRAM_AUTO_CLEAR_EN, CLEAR_VALUE=0x5A5A:
  - busy is high for 512 cycles after reset; rd_en during busy yields no rd_valid.
  - After busy falls, addr 0, 255 and 511 read 0x5A5A.
  - A reset pulse at clear cycle 100 restarts the clear: busy is high for a full 512 cycles again.
